branch_resolve_unit: RTL and testbench

//   EX-side partner of the branch predictor. Records each fetched PC and the predicted next-PC in an
//   in-flight FIFO, resolves them in order against EX outcomes, and drives the predictor's training and

---
 rtl/branch_resolve_unit_pkg.sv | 33 +++
 rtl/branch_resolve_unit_pred_fifo.sv | 71 +++++++
 rtl/branch_resolve_unit.sv | 128 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: instruction size and
// the flag bundles driven towards the predictor in the idle and squashed cases.
package branch_resolve_unit_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic branch;
    logic branch_taken;
    logic ret;
    logic predicted;
    logic flush;
  } resolve_flags_t;

  // Nothing resolving: the predictor sees "prediction fine, nothing to train".
  localparam resolve_flags_t IDLE_FLAGS = '{
    branch:       1'b0,
    branch_taken: 1'b0,
    ret:          1'b0,
    predicted:    1'b1,
    flush:        1'b0
  };

  // Wrong-path instruction: squash it, never train or redirect from it.
  localparam resolve_flags_t KILLED_FLAGS = '{
    branch:       1'b0,
    branch_taken: 1'b0,
    ret:          1'b0,
    predicted:    1'b1,
    flush:        1'b1
  };

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-flight FIFO of {pc, predicted next-pc} with a kill bit per entry.
// A mispredict marks every entry still queued (and optionally the one being
// written this cycle) as wrong-path so they drain as squashed instructions.
module pred_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [ADDR_WIDTH-1:0] push_prd,
  input  logic                  kill_all_remaining,
  input  logic                  kill_on_push,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [ADDR_WIDTH-1:0] head_prd,
  output logic                  head_kill,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] prd_mem [DEPTH];
  logic [DEPTH-1:0]      kill_mem;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [LVL_W-1:0]      level;

  // Pointers, occupancy and kill bits; kill_all_remaining may touch empty slots
  // harmlessly because every push rewrites its own kill bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      kill_mem <= '0;
    end else begin
      if (kill_all_remaining) begin
        kill_mem <= '1;
      end
      if (push) begin
        kill_mem[wr_ptr] <= kill_on_push;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]  <= push_pc;
      prd_mem[wr_ptr] <= push_prd;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_prd  = prd_mem[rd_ptr];
  assign head_kill = kill_mem[rd_ptr];
  assign empty     = (level == '0);
  assign full      = (level == DEPTH_LVL);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-side partner of the branch predictor: resolves fetched instructions in
// order against EX outcomes, drives training/redirect signals, squashes
// wrong-path instructions and counts branches and mispredictions.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic                  IF_VALID,
  input  logic [ADDR_WIDTH-1:0] IF_PC,
  input  logic [ADDR_WIDTH-1:0] IF_PRD_ADDR,
  input  logic                  EX_VALID,
  input  logic [ADDR_WIDTH-1:0] EX_PC_IN,
  input  logic                  EX_IS_BRANCH,
  input  logic                  EX_TAKEN,
  input  logic [ADDR_WIDTH-1:0] EX_TARGET,
  input  logic                  EX_IS_RETURN,
  output logic                  BRANCH,
  output logic                  BRANCH_TAKEN,
  output logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
  output logic                  RETURN,
  output logic                  PREDICTED,
  output logic                  FLUSH,
  output logic [ADDR_WIDTH-1:0] EX_PC,
  output logic                  FIFO_FULL,
  output logic                  MISMATCH_ERR,
  output logic [CNT_WIDTH-1:0]  BRANCH_COUNT,
  output logic [CNT_WIDTH-1:0]  MISPREDICT_COUNT
);

  logic                  adv;
  logic                  pop;
  logic                  push;
  logic                  empty;
  logic                  fifo_at_depth;
  logic                  head_kill;
  logic                  live;
  logic                  match;
  logic                  mispredict;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [ADDR_WIDTH-1:0] head_prd;
  logic [ADDR_WIDTH-1:0] actual_next;
  resolve_flags_t        flags;

  assign adv  = CACHE_READY & CACHE_READY_DATA;
  assign pop  = adv & EX_VALID & !empty;
  assign push = adv & IF_VALID & (!fifo_at_depth | pop);

  assign FIFO_FULL = fifo_at_depth & !pop;

  assign actual_next = (EX_IS_BRANCH & EX_TAKEN) ? EX_TARGET
                                                 : EX_PC_IN + ADDR_WIDTH'(INSTR_BYTES);
  assign match       = (head_prd == actual_next);
  assign live        = EX_VALID & !empty & !head_kill;
  assign mispredict  = pop & live & !match;

  pred_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_pred_fifo (
    .CLK                (CLK),
    .RST                (RST),
    .push               (push),
    .pop                (pop),
    .push_pc            (IF_PC),
    .push_prd           (IF_PRD_ADDR),
    .kill_all_remaining (mispredict),
    .kill_on_push       (mispredict),
    .head_pc            (head_pc),
    .head_prd           (head_prd),
    .head_kill          (head_kill),
    .empty              (empty),
    .full               (fifo_at_depth)
  );

  // Select idle, squashed or live resolution results for the predictor.
  always_comb begin
    flags       = IDLE_FLAGS;
    BRANCH_ADDR = '0;
    EX_PC       = '0;
    if (EX_VALID && !empty) begin
      BRANCH_ADDR = EX_TARGET;
      EX_PC       = EX_PC_IN;
      if (head_kill) begin
        flags = KILLED_FLAGS;
      end else begin
        flags.branch       = EX_IS_BRANCH;
        flags.branch_taken = EX_TAKEN;
        flags.ret          = EX_IS_RETURN;
        flags.predicted    = match;
        flags.flush        = 1'b0;
      end
    end
  end

  assign BRANCH       = flags.branch;
  assign BRANCH_TAKEN = flags.branch_taken;
  assign RETURN       = flags.ret;
  assign PREDICTED    = flags.predicted;
  assign FLUSH        = flags.flush;

  // Performance counters advance only for instructions that actually retire from EX.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BRANCH_COUNT     <= '0;
      MISPREDICT_COUNT <= '0;
    end else if (pop && live) begin
      BRANCH_COUNT     <= BRANCH_COUNT + CNT_WIDTH'(EX_IS_BRANCH);
      MISPREDICT_COUNT <= MISPREDICT_COUNT + CNT_WIDTH'(!match);
    end
  end

  // Sticky flag for EX reporting with nothing queued or for the wrong PC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MISMATCH_ERR <= 1'b0;
    end else if ((adv && EX_VALID && empty) || (pop && (head_pc != EX_PC_IN))) begin
      MISMATCH_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: reset, correct and wrong
// predictions, squashing, full/stall handling, PC wrap and error/reset cases.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        cache_ready;
  logic        cache_ready_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_prd_addr;
  logic        ex_valid;
  logic [31:0] ex_pc_in;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_is_return;
  logic        branch;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        ret;
  logic        predicted;
  logic        flush;
  logic [31:0] ex_pc;
  logic        fifo_full;
  logic        mismatch_err;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(
    .ADDR_WIDTH (32),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (32)
  ) dut (
    .CLK              (clk),
    .RST              (rst),
    .CACHE_READY      (cache_ready),
    .CACHE_READY_DATA (cache_ready_data),
    .IF_VALID         (if_valid),
    .IF_PC            (if_pc),
    .IF_PRD_ADDR      (if_prd_addr),
    .EX_VALID         (ex_valid),
    .EX_PC_IN         (ex_pc_in),
    .EX_IS_BRANCH     (ex_is_branch),
    .EX_TAKEN         (ex_taken),
    .EX_TARGET        (ex_target),
    .EX_IS_RETURN     (ex_is_return),
    .BRANCH           (branch),
    .BRANCH_TAKEN     (branch_taken),
    .BRANCH_ADDR      (branch_addr),
    .RETURN           (ret),
    .PREDICTED        (predicted),
    .FLUSH            (flush),
    .EX_PC            (ex_pc),
    .FIFO_FULL        (fifo_full),
    .MISMATCH_ERR     (mismatch_err),
    .BRANCH_COUNT     (branch_count),
    .MISPREDICT_COUNT (mispredict_count)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic        ifv,
                               input logic [31:0] ifpc,
                               input logic [31:0] ifprd,
                               input logic        exv,
                               input logic [31:0] expc,
                               input logic        isbr,
                               input logic        tkn,
                               input logic [31:0] tgt,
                               input logic        isret);
    if_valid     = ifv;
    if_pc        = ifpc;
    if_prd_addr  = ifprd;
    ex_valid     = exv;
    ex_pc_in     = expc;
    ex_is_branch = isbr;
    ex_taken     = tkn;
    ex_target    = tgt;
    ex_is_return = isret;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    cache_ready = 1'b1;
    cache_ready_data = 1'b1;
    idle();
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_predicted", {31'b0, predicted}, 32'h1);
    checkOutput("rst_flush", {31'b0, flush}, 32'h0);
    checkOutput("rst_full", {31'b0, fifo_full}, 32'h0);
    checkOutput("rst_bcnt", branch_count, 32'h0);
    checkOutput("rst_mcnt", mispredict_count, 32'h0);
    checkOutput("rst_err", {31'b0, mismatch_err}, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] correct prediction");
    applyStimulus(1'b1, 32'h100, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0);
    checkOutput("ok_predicted", {31'b0, predicted}, 32'h1);
    checkOutput("ok_branch", {31'b0, branch}, 32'h1);
    checkOutput("ok_taken", {31'b0, branch_taken}, 32'h1);
    checkOutput("ok_flush", {31'b0, flush}, 32'h0);
    checkOutput("ok_expc", ex_pc, 32'h100);
    tick();
    idle();
    checkOutput("ok_bcnt", branch_count, 32'h1);
    checkOutput("ok_mcnt", mispredict_count, 32'h0);

    $display("[TB] mispredict and squash");
    applyStimulus(1'b1, 32'h100, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h104, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h108, 32'h10C, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h10C, 32'h110, 1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b0);
    checkOutput("mp_predicted", {31'b0, predicted}, 32'h0);
    checkOutput("mp_addr", branch_addr, 32'h300);
    checkOutput("mp_flush", {31'b0, flush}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b1, 32'h500, 1'b1);
    checkOutput("sq1_flush", {31'b0, flush}, 32'h1);
    checkOutput("sq1_predicted", {31'b0, predicted}, 32'h1);
    checkOutput("sq1_branch", {31'b0, branch}, 32'h0);
    checkOutput("sq1_return", {31'b0, ret}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sq2_flush", {31'b0, flush}, 32'h1);
    checkOutput("sq2_predicted", {31'b0, predicted}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h10C, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("sq3_flush", {31'b0, flush}, 32'h1);
    checkOutput("sq3_predicted", {31'b0, predicted}, 32'h1);
    tick();
    idle();
    checkOutput("mp_bcnt", branch_count, 32'h2);
    checkOutput("mp_mcnt", mispredict_count, 32'h1);
    applyStimulus(1'b1, 32'h300, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_flush", {31'b0, flush}, 32'h0);
    checkOutput("post_predicted", {31'b0, predicted}, 32'h1);
    tick();
    idle();
    checkOutput("post_err", {31'b0, mismatch_err}, 32'h0);

    $display("[TB] full and stall");
    applyStimulus(1'b1, 32'h400, 32'h404, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h404, 32'h408, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h408, 32'h40C, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("fill3_full", {31'b0, fifo_full}, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h40C, 32'h410, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h999, 32'h99D, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("full_at4", {31'b0, fifo_full}, 32'h1);
    tick();
    idle();
    checkOutput("full_after5", {31'b0, fifo_full}, 32'h1);
    applyStimulus(1'b1, 32'h410, 32'h414, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pp_full", {31'b0, fifo_full}, 32'h0);
    checkOutput("pp_predicted", {31'b0, predicted}, 32'h1);
    tick();
    idle();
    checkOutput("pp_full_after", {31'b0, fifo_full}, 32'h1);
    cache_ready = 1'b0;
    applyStimulus(1'b1, 32'h500, 32'h504, 1'b1, 32'h404, 1'b1, 1'b1, 32'h408, 1'b0);
    checkOutput("stall_branch", {31'b0, branch}, 32'h1);
    checkOutput("stall_full", {31'b0, fifo_full}, 32'h1);
    tick();
    cache_ready = 1'b1;
    idle();
    checkOutput("stall_bcnt", branch_count, 32'h2);
    checkOutput("stall_full_after", {31'b0, fifo_full}, 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h404, 1'b1, 1'b1, 32'h408, 1'b0);
    checkOutput("drain1_predicted", {31'b0, predicted}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h408, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("drain2_predicted", {31'b0, predicted}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h40C, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("drain3_predicted", {31'b0, predicted}, 32'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h410, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("drain4_predicted", {31'b0, predicted}, 32'h1);
    checkOutput("drain4_expc", ex_pc, 32'h410);
    tick();
    idle();
    checkOutput("drain_bcnt", branch_count, 32'h3);
    checkOutput("drain_mcnt", mispredict_count, 32'h1);
    checkOutput("drain_err", {31'b0, mismatch_err}, 32'h0);
    checkOutput("drain_full", {31'b0, fifo_full}, 32'h0);

    $display("[TB] pc wrap-around");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h800, 1'b0);
    checkOutput("wrap_predicted", {31'b0, predicted}, 32'h1);
    checkOutput("wrap_expc", ex_pc, 32'hFFFF_FFFC);
    tick();
    idle();
    checkOutput("wrap_mcnt", mispredict_count, 32'h1);
    checkOutput("wrap_bcnt", branch_count, 32'h4);

    $display("[TB] pc mismatch error");
    applyStimulus(1'b1, 32'h700, 32'h704, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h708, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("pcerr_predicted", {31'b0, predicted}, 32'h0);
    checkOutput("pcerr_expc", ex_pc, 32'h708);
    tick();
    idle();
    checkOutput("pcerr_err", {31'b0, mismatch_err}, 32'h1);
    checkOutput("pcerr_mcnt", mispredict_count, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst1_err", {31'b0, mismatch_err}, 32'h0);
    checkOutput("rst1_bcnt", branch_count, 32'h0);
    checkOutput("rst1_mcnt", mispredict_count, 32'h0);
    #1;
    rst = 1'b0;
    tick();

    $display("[TB] empty EX error");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h777, 1'b1, 1'b1, 32'h123, 1'b1);
    checkOutput("empty_predicted", {31'b0, predicted}, 32'h1);
    checkOutput("empty_branch", {31'b0, branch}, 32'h0);
    checkOutput("empty_return", {31'b0, ret}, 32'h0);
    checkOutput("empty_addr", branch_addr, 32'h0);
    checkOutput("empty_expc", ex_pc, 32'h0);
    tick();
    idle();
    checkOutput("empty_err", {31'b0, mismatch_err}, 32'h1);
    checkOutput("empty_bcnt", branch_count, 32'h0);
    tick();
    checkOutput("sticky_err", {31'b0, mismatch_err}, 32'h1);

    $display("[TB] reset with entries queued");
    applyStimulus(1'b1, 32'h600, 32'h604, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h604, 32'h608, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h608, 32'h60C, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    idle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst2_err", {31'b0, mismatch_err}, 32'h0);
    checkOutput("rst2_full", {31'b0, fifo_full}, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b1, 32'h604, 1'b0);
    checkOutput("rst2_empty_expc", ex_pc, 32'h0);
    checkOutput("rst2_empty_branch", {31'b0, branch}, 32'h0);
    tick();
    idle();
    checkOutput("rst2_empty_err", {31'b0, mismatch_err}, 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
